// File: rtl/sd_otfc_converter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sd_pkg
//  Description : Shared types for the online signed-digit datapath. Holds the
//                radix-2 signed-digit encoding {p,n} (value = p - n) and the
//                state type of the on-the-fly converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package sd_pkg;

    typedef logic [1:0] signed_digit;

    localparam signed_digit SD_ZERO = 2'b00;
    localparam signed_digit SD_NEG  = 2'b01;
    localparam signed_digit SD_POS  = 2'b10;
    localparam signed_digit SD_ILL  = 2'b11;   // both rails set; decodes as 0

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        DONE = 2'b10
    } otfc_state_t;

endpackage : sd_pkg
`default_nettype wire

// File: rtl/sd_otfc_converter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sd_otfc_converter_if
//  Description : Digit-in / word-out handshake bundle of the OTFC converter.
//                  in_valid/in_ready/in_digit    : serial signed-digit stream
//                  out_valid/out_ready/out_data  : completed WIDTH+1 bit word
//                  err (SD_OTFC_ILLEGAL_CHECK_EN): word contained digit 2'b11
//                modport master : digit producer / word consumer side
//                modport slave  : the converter itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface sd_otfc_converter_if
    import sd_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic              in_valid;
    logic              in_ready;
    signed_digit       in_digit;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH:0]    out_data;

`ifdef SD_OTFC_ILLEGAL_CHECK_EN
    logic              err;

    modport master (output in_valid, in_digit, out_ready,
                    input  in_ready, out_valid, out_data, err);
    modport slave  (input  in_valid, in_digit, out_ready,
                    output in_ready, out_valid, out_data, err);
`else
    modport master (output in_valid, in_digit, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_digit, out_ready,
                    output in_ready, out_valid, out_data);
`endif

endinterface : sd_otfc_converter_if
`default_nettype wire

// File: rtl/sd_otfc_converter_step.sv
`default_nettype none
// ============================================================================
//  Module      : sd_otfc_step
//  Description : One on-the-fly conversion step. Appends a signed digit to
//                the Q/QM pair (QM = Q - 1) without any carry propagation:
//                  +1 : Q <- {Q,1}   QM <- {Q,0}
//                   0 : Q <- {Q,0}   QM <- {QM,1}
//                  -1 : Q <- {QM,1}  QM <- {QM,0}
//                Pure combinational, so it can be replicated for an unrolled
//                converter.
//  Ports       : q, qm, digit (in); q_next, qm_next (out)
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_otfc_step
    import sd_pkg::*;
#(
    parameter int QW = 33
) (
    input  logic [QW-1:0] q,
    input  logic [QW-1:0] qm,
    input  signed_digit   digit,
    output logic [QW-1:0] q_next,
    output logic [QW-1:0] qm_next
);

    always_comb begin
        // zero digit (and the illegal 2'b11 code) is the default
        q_next  = (q  << 1);
        qm_next = (qm << 1) | QW'(1);
        case (digit)
            SD_POS: begin
                q_next  = (q << 1) | QW'(1);
                qm_next = (q << 1);
            end
            SD_NEG: begin
                q_next  = (qm << 1) | QW'(1);
                qm_next = (qm << 1);
            end
            default: ;
        endcase
    end

endmodule : sd_otfc_step
`default_nettype wire

// File: rtl/sd_otfc_converter.sv
`default_nettype none
// ============================================================================
//  Module      : sd_otfc_converter
//  Description : Converts a radix-2 signed-digit stream (MSD first, one digit
//                per cycle) into a WIDTH+1 bit two's-complement word using
//                on-the-fly conversion. Result Q represents Q * 2^-WIDTH.
//                WIDTH must be >= 2.
//  Ports       : clk, rst_n (synchronous, active-low)
//                bus (sd_otfc_converter_if.slave): digit input handshake,
//                word output handshake, optional err flag.
//  Options     : SD_OTFC_ILLEGAL_CHECK_EN - adds sticky per-word err flag
//                raised by an accepted 2'b11 digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_otfc_converter
    import sd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sd_otfc_converter_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int QW    = WIDTH + 1;

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_ACC  = 2'(ACC);
    localparam logic [1:0] S_DONE = 2'(DONE);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [QW-1:0]    q_q,     q_d;
    logic [QW-1:0]    qm_q,    qm_d;
    logic [QW-1:0]    data_q,  data_d;

    logic             accept;
    logic             fresh;
    logic [QW-1:0]    base_q, base_qm;
    logic [QW-1:0]    step_q, step_qm;

    // Outputs are forced low while reset is asserted, not just after the edge.
    assign bus.in_ready  = rst_n & ((state_q != S_DONE) | bus.out_ready);
    assign bus.out_valid = rst_n & (state_q == S_DONE);
    assign bus.out_data  = rst_n ? data_q : '0;

    assign accept = bus.in_valid & bus.in_ready;

    // Any digit accepted outside ACC is the first of a new word, so it
    // starts from Q=0 / QM=-1 regardless of what the registers hold.
    assign fresh   = (state_q != S_ACC);
    assign base_q  = fresh ? '0 : q_q;
    assign base_qm = fresh ? '1 : qm_q;

    sd_otfc_step #(.QW(QW)) u_step (
        .q       (base_q),
        .qm      (base_qm),
        .digit   (bus.in_digit),
        .q_next  (step_q),
        .qm_next (step_qm)
    );

`ifdef SD_OTFC_ILLEGAL_CHECK_EN
    logic err_acc_q, err_acc_d;   // sticky flag for the word in progress
    logic err_q,     err_d;       // flag presented alongside out_valid
    logic ill;

    assign ill     = accept & (bus.in_digit == SD_ILL);
    assign bus.err = rst_n & err_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        qm_d    = qm_q;
        data_d  = data_q;
`ifdef SD_OTFC_ILLEGAL_CHECK_EN
        err_acc_d = err_acc_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    q_d     = step_q;
                    qm_d    = step_qm;
                    cnt_d   = CNT_W'(1);
                    state_d = S_ACC;
`ifdef SD_OTFC_ILLEGAL_CHECK_EN
                    err_acc_d = ill;
`endif
                end
            end
            S_ACC: begin
                if (accept) begin
                    q_d   = step_q;
                    qm_d  = step_qm;
                    cnt_d = cnt_q + 1'b1;
`ifdef SD_OTFC_ILLEGAL_CHECK_EN
                    err_acc_d = err_acc_q | ill;
`endif
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_DONE;
                        data_d  = step_q;
`ifdef SD_OTFC_ILLEGAL_CHECK_EN
                        err_d = err_acc_q | ill;
`endif
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
`ifdef SD_OTFC_ILLEGAL_CHECK_EN
                    err_d = 1'b0;
`endif
                    if (bus.in_valid) begin
                        // hand-off and first digit of the next word together
                        q_d     = step_q;
                        qm_d    = step_qm;
                        cnt_d   = CNT_W'(1);
                        state_d = S_ACC;
`ifdef SD_OTFC_ILLEGAL_CHECK_EN
                        err_acc_d = ill;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            qm_q    <= '1;
            data_q  <= '0;
`ifdef SD_OTFC_ILLEGAL_CHECK_EN
            err_acc_q <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            qm_q    <= qm_d;
            data_q  <= data_d;
`ifdef SD_OTFC_ILLEGAL_CHECK_EN
            err_acc_q <= err_acc_d;
            err_q     <= err_d;
`endif
        end
    end

endmodule : sd_otfc_converter
`default_nettype wire
